axis_pgroup_packer: RTL and testbench
=====================================

AXIS_PGROUP_PACKER -- requirements
Module: axis_pgroup_packer

Interface
REQ-001 SHALL have parameter IN_DATA_W, default 64, meaning the AXI4 read-data width.
REQ-002 SHALL have parameter OUT_DATA_W, default 256, meaning the pixel-group width; OUT_DATA_W/IN_DATA_W (RATIO) is a power of two ≥2.
REQ-003 SHALL have parameter AXIS_TID_W, default 2, meaning the stream ID width.
REQ-004 SHALL have parameter AXIS_TDEST_W, default 1, meaning the stream destination width.
REQ-005 SHALL have parameter FRAME_PGROUPS, default 1200, meaning the number of pixel groups per frame (≥1).
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-008 SHALL have ports s_rdata_i (input, IN_DATA_W), s_rresp_i (input, 2), s_rlast_i (input, 1), s_rvalid_i (input, 1) and s_rready_o (output, 1), forming the AXI4 R channel.
REQ-009 SHALL have ports cfg_tid_i (input, AXIS_TID_W) and cfg_tdest_i (input, AXIS_TDEST_W), quasi-static stream tags.
REQ-010 SHALL have ports m_tid_o, m_tdest_o, m_tdata_o (OUT_DATA_W), m_tkeep_o, m_tstrb_o (OUT_DATA_W/8 each), m_tlast_o, m_tvalid_o (outputs) and m_tready_i (input), forming the AXI-Stream master.
REQ-011 SHALL have ports err_o (output, 1; sticky RRESP error) and err_clr_i (input, 1).

Function
REQ-012 SHALL pack RATIO accepted R beats into one group, little-endian: beat k occupies bits [k*IN_DATA_W +: IN_DATA_W].
REQ-013 SHALL use a lane counter (0..RATIO-1) that increments on each R handshake and wraps to 0 when the group completes.
REQ-014 SHALL use a registered output slot; the completed group is loaded into it on the clock edge of the final beat's handshake, so m_tvalid_o rises one cycle after that handshake.
REQ-015 SHALL drive s_rready_o = ~(lane==RATIO-1 or s_rlast_i) | ~m_tvalid_o | m_tready_i, sustaining one beat per cycle without back-pressure.
REQ-016 SHALL keep m_tdata_o, m_tlast_o, m_tid_o and m_tdest_o stable while m_tvalid_o=1 and m_tready_i=0.
REQ-017 SHALL sample cfg_tid_i and cfg_tdest_i into the slot at load time.
REQ-018 SHALL drive m_tkeep_o and m_tstrb_o to all-ones.
REQ-019 SHALL count emitted groups 0..FRAME_PGROUPS-1 and set m_tlast_o for group FRAME_PGROUPS-1; the counter wraps to 0 on that group's load.
REQ-020 SHALL treat s_rlast_i=1 on a non-final lane as completing a partial group: zero-pad the remaining lanes, reset the lane counter to 0, and count the group as a full group.
REQ-021 SHALL, on a simultaneous output handshake and new load in the same cycle, load the new group and keep m_tvalid_o=1.
REQ-022 SHALL, with FRAME_PGROUPS=1, assert m_tlast_o on every group.

Reset
REQ-023 SHALL, while rst_n=0, clear immediately: m_tvalid_o=0, m_tlast_o=0, m_tdata_o=0, m_tid_o=0, m_tdest_o=0, lane counter=0, group counter=0, err_o=0; s_rready_o=1.
REQ-024 SHALL discard any partial group and any pending output when reset is asserted mid-frame; the first group after reset has group index 0.

Configuration
REQ-025 SHALL, with macro AXIS_PGROUP_PACKER_ERR_EN defined, set err_o on any R handshake with s_rresp_i≠2'b00, hold it until err_clr_i=1, and let a same-cycle set win over clear.
REQ-026 SHALL, without AXIS_PGROUP_PACKER_ERR_EN, keep all ports, ignore s_rresp_i and err_clr_i, and tie err_o to 0.

Verification
REQ-027 SHALL cover: 4 beats 0x11..,0x22..,0x33..,0x44.. with m_tready_i=1 -> one group with tdata[63:0]=0x11.., tdata[255:192]=0x44.., tvalid one cycle after beat 4.
REQ-028 SHALL cover: FRAME_PGROUPS=3, 12 continuous beats -> 3 groups, m_tlast_o only on the third, next group's tlast=0.
REQ-029 SHALL cover: m_tready_i=0 for 10 cycles with full output slot and lane=3 -> s_rready_o=0, tdata stable; on release, no beat lost or duplicated.
REQ-030 SHALL cover: s_rlast_i on lane 1 -> group emitted with lanes 2-3 zero; the next beat lands in lane 0.
REQ-031 SHALL cover: rst_n low mid-group (lane 2) -> tvalid=0 immediately; after release, 4 beats produce a group containing only the post-reset data with group index 0.
REQ-032 SHALL cover: with ERR_EN, rresp=2'b10 on one beat -> err_o=1 next cycle and sticky; err_clr_i pulse -> 0; without ERR_EN -> err_o stays 0.

Source files
------------

// File: rtl/axis_pgroup_packer.sv
// rtl/axis_pgroup_packer.sv - packs AXI4 R beats into pixel groups on an AXI-Stream master
// Optional RRESP error flag enabled by defining AXIS_PGROUP_PACKER_ERR_EN.
module axis_pgroup_packer #(
  parameter int IN_DATA_W     = 64,
  parameter int OUT_DATA_W    = 256,
  parameter int AXIS_TID_W    = 2,
  parameter int AXIS_TDEST_W  = 1,
  parameter int FRAME_PGROUPS = 1200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_DATA_W-1:0]      s_rdata_i,
  input  logic [1:0]                s_rresp_i,
  input  logic                      s_rlast_i,
  input  logic                      s_rvalid_i,
  output logic                      s_rready_o,
  input  logic [AXIS_TID_W-1:0]     cfg_tid_i,
  input  logic [AXIS_TDEST_W-1:0]   cfg_tdest_i,
  output logic [AXIS_TID_W-1:0]     m_tid_o,
  output logic [AXIS_TDEST_W-1:0]   m_tdest_o,
  output logic [OUT_DATA_W-1:0]     m_tdata_o,
  output logic [OUT_DATA_W/8-1:0]   m_tkeep_o,
  output logic [OUT_DATA_W/8-1:0]   m_tstrb_o,
  output logic                      m_tlast_o,
  output logic                      m_tvalid_o,
  input  logic                      m_tready_i,
  output logic                      err_o,
  input  logic                      err_clr_i
);

  localparam int RATIO  = OUT_DATA_W / IN_DATA_W;
  localparam int LANE_W = $clog2(RATIO);
  localparam int GRP_W  = (FRAME_PGROUPS > 1) ? $clog2(FRAME_PGROUPS) : 1;

  logic [LANE_W-1:0]     lane;
  logic [GRP_W-1:0]      grp;
  logic [OUT_DATA_W-1:0] acc;
  logic [OUT_DATA_W-1:0] group_data;
  logic                  final_beat;
  logic                  r_hs;
  logic                  load;
  logic                  grp_last;

  // A beat closes the group on the top lane or on an early rlast; only such
  // beats need room in the output slot, so partial lanes keep flowing.
  assign final_beat = (lane == LANE_W'(RATIO - 1)) || s_rlast_i;
  assign s_rready_o = ~final_beat | ~m_tvalid_o | m_tready_i;
  assign r_hs       = s_rvalid_i & s_rready_o;
  assign load       = r_hs & final_beat;
  assign grp_last   = (grp == GRP_W'(FRAME_PGROUPS - 1));

  // acc holds zeros above the current lane, which provides the padding for
  // groups cut short by rlast.
  assign group_data = acc | (OUT_DATA_W'(s_rdata_i) << (lane * IN_DATA_W));

  assign m_tkeep_o = '1;
  assign m_tstrb_o = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane       <= '0;
      grp        <= '0;
      acc        <= '0;
      m_tvalid_o <= 1'b0;
      m_tlast_o  <= 1'b0;
      m_tdata_o  <= '0;
      m_tid_o    <= '0;
      m_tdest_o  <= '0;
    end else begin
      if (r_hs) begin
        if (final_beat) begin
          lane <= '0;
          acc  <= '0;
        end else begin
          lane <= lane + 1'b1;
          acc  <= group_data;
        end
      end
      if (load) begin
        m_tvalid_o <= 1'b1;
        m_tdata_o  <= group_data;
        m_tid_o    <= cfg_tid_i;
        m_tdest_o  <= cfg_tdest_i;
        m_tlast_o  <= grp_last;
        grp        <= grp_last ? '0 : grp + 1'b1;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end
    end
  end

`ifdef AXIS_PGROUP_PACKER_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (r_hs && (s_rresp_i != 2'b00)) begin
      err_q <= 1'b1;
    end else if (err_clr_i) begin
      err_q <= 1'b0;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pgroup_packer.sv
// tb/tb_axis_pgroup_packer.sv - randomized self-checking bench for axis_pgroup_packer
module tb_axis_pgroup_packer;

  localparam int IW    = 64;
  localparam int OW    = 256;
  localparam int RATIO = OW / IW;
  localparam int FRAME = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          s_rvalid;
  logic          s_rready;
  logic [1:0]    cfg_tid;
  logic          cfg_tdest;
  logic [1:0]    m_tid;
  logic          m_tdest;
  logic [OW-1:0] m_tdata;
  logic [OW/8-1:0] m_tkeep;
  logic [OW/8-1:0] m_tstrb;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic          err;
  logic          err_clr;

  axis_pgroup_packer #(
    .IN_DATA_W(IW), .OUT_DATA_W(OW), .AXIS_TID_W(2), .AXIS_TDEST_W(1), .FRAME_PGROUPS(FRAME)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_rdata_i(s_rdata), .s_rresp_i(s_rresp), .s_rlast_i(s_rlast),
    .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
    .cfg_tid_i(cfg_tid), .cfg_tdest_i(cfg_tdest),
    .m_tid_o(m_tid), .m_tdest_o(m_tdest), .m_tdata_o(m_tdata),
    .m_tkeep_o(m_tkeep), .m_tstrb_o(m_tstrb), .m_tlast_o(m_tlast),
    .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .err_o(err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          last;
    logic [1:0]    tid;
    logic          tdest;
  } grp_t;

  grp_t          exp_q[$];
  logic [IW-1:0] cur[$];
  int            frame_cnt = 0;
  int            tlast_seen = 0;
  int            checks = 0;
  int            passes = 0;

  // Reference: beats gather into a list; a group is closed by RATIO beats or rlast,
  // zero-padded, and its tlast comes from its position within the frame.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur.delete();
      frame_cnt = 0;
    end else begin
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_group: got tdata %h, required no group", m_tdata);
        end else if (m_tdata !== exp_q[0].data || m_tlast !== exp_q[0].last ||
                     m_tid !== exp_q[0].tid || m_tdest !== exp_q[0].tdest ||
                     m_tkeep !== '1 || m_tstrb !== '1) begin
          $display("FAIL group: got data=%h last=%b tid=%h dest=%b keep=%h, required data=%h last=%b tid=%h dest=%b keep=all-ones",
                   m_tdata, m_tlast, m_tid, m_tdest, m_tkeep,
                   exp_q[0].data, exp_q[0].last, exp_q[0].tid, exp_q[0].tdest);
          void'(exp_q.pop_front());
        end else begin
          passes++;
          void'(exp_q.pop_front());
        end
        if (m_tlast) tlast_seen++;
      end
      if (s_rvalid && s_rready) begin
        cur.push_back(s_rdata);
        if (s_rlast || cur.size() == RATIO) begin
          grp_t g;
          g.data = '0;
          for (int i = 0; i < cur.size(); i++) g.data[i*IW +: IW] = cur[i];
          g.last  = (frame_cnt == FRAME - 1);
          g.tid   = cfg_tid;
          g.tdest = cfg_tdest;
          frame_cnt = (frame_cnt + 1) % FRAME;
          exp_q.push_back(g);
          cur.delete();
        end
      end
    end
  end

  task automatic send_beat(input logic [IW-1:0] d, input logic l, input logic [1:0] r);
    int  n = 0;
    logic ok;
    s_rdata = d; s_rlast = l; s_rresp = r; s_rvalid = 1'b1;
    do begin
      @(negedge clk); ok = s_rready;
      @(posedge clk); #1;
      n++;
      if (!ok && n > 4) m_tready = 1'b1;
    end while (!ok && n < 50);
    checks++;
    if (!ok) $display("FAIL beat_timeout: got no s_rready in %0d cycles, required acceptance", n);
    else passes++;
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rresp = 2'b00;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    m_tready = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || m_tvalid !== 1'b0 || cur.size() != 0)
      $display("FAIL %s_drain: got %0d pending groups tvalid=%b, required 0 and 0", name, exp_q.size(), m_tvalid);
    else passes++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0 || m_tid !== '0 ||
        m_tdest !== 1'b0 || s_rready !== 1'b1 || err !== 1'b0)
      $display("FAIL reset_state: got tvalid=%b tlast=%b tdata=%h tid=%h tdest=%b rready=%b err=%b, required 0,0,0,0,0,1,0",
               m_tvalid, m_tlast, m_tdata, m_tid, m_tdest, s_rready, err);
    else passes++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [IW-1:0] b[4];
    b[0] = {16{4'h1}}; b[1] = {16{4'h2}}; b[2] = {16{4'h3}}; b[3] = {16{4'h4}};
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send_beat(b[i], 1'b0, 2'b00);
    checks++;
    if (m_tvalid !== 1'b0) $display("FAIL basic_early_valid: got tvalid=%b, required 0", m_tvalid);
    else passes++;
    send_beat(b[3], 1'b0, 2'b00);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata[63:0] !== b[0] || m_tdata[255:192] !== b[3])
      $display("FAIL basic_group: got tvalid=%b lo=%h hi=%h, required 1 %h %h",
               m_tvalid, m_tdata[63:0], m_tdata[255:192], b[0], b[3]);
    else passes++;
    drain("basic");
  endtask

  task automatic test_frame();
    do_reset();
    tlast_seen = 0;
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) send_beat({$urandom, $urandom}, 1'b0, 2'b00);
    drain("frame");
    checks++;
    if (tlast_seen != 1) $display("FAIL frame_tlast_count: got %0d, required 1", tlast_seen);
    else passes++;
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held;
    int bad = 0;
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) send_beat({$urandom, $urandom}, 1'b0, 2'b00);
    held = exp_q[0].data;
    s_rdata = {$urandom, $urandom}; s_rvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_rready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== held) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) $display("FAIL backpressure_hold: got %0d bad cycles, required 0", bad);
    else passes++;
    m_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_rready !== 1'b1) $display("FAIL backpressure_release: got rready=%b, required 1", s_rready);
    else passes++;
    @(posedge clk); #1;
    s_rvalid = 1'b0;
    checks++;
    if (m_tvalid !== 1'b1) $display("FAIL swap_valid: got tvalid=%b, required 1", m_tvalid);
    else passes++;
    drain("backpressure");
  endtask

  task automatic test_partial();
    m_tready = 1'b1;
    send_beat({$urandom, $urandom}, 1'b0, 2'b00);
    send_beat({$urandom, $urandom}, 1'b1, 2'b00);
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata[255:128] !== '0)
      $display("FAIL partial_pad: got tvalid=%b upper=%h, required 1 and zero", m_tvalid, m_tdata[255:128]);
    else passes++;
    for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom}, 1'b0, 2'b00);
    drain("partial");
  endtask

  task automatic test_reset_mid();
    logic [IW-1:0] b[4];
    logic [OW-1:0] want;
    m_tready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat({$urandom, $urandom}, 1'b0, 2'b00);
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== '0)
      $display("FAIL reset_mid_async: got tvalid=%b tdata=%h, required 0 and 0", m_tvalid, m_tdata);
    else passes++;
    @(negedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b[i] = {$urandom, $urandom};
      want[i*IW +: IW] = b[i];
      send_beat(b[i], 1'b0, 2'b00);
    end
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== want || m_tlast !== 1'b0)
      $display("FAIL reset_mid_group: got tvalid=%b tdata=%h tlast=%b, required 1 %h 0", m_tvalid, m_tdata, m_tlast, want);
    else passes++;
    drain("reset_mid");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      cfg_tid = 2'($urandom); cfg_tdest = 1'($urandom);
      send_beat({$urandom, $urandom}, (i == 39) || ($urandom_range(0, 7) == 0), 2'b00);
    end
    drain("random");
  endtask

  task automatic test_err();
    logic want_err;
`ifdef AXIS_PGROUP_PACKER_ERR_EN
    want_err = 1'b1;
`else
    want_err = 1'b0;
`endif
    m_tready = 1'b1;
    send_beat({$urandom, $urandom}, 1'b0, 2'b10);
    checks++;
    if (err !== want_err) $display("FAIL err_set: got %b, required %b", err, want_err);
    else passes++;
    send_beat({$urandom, $urandom}, 1'b1, 2'b00);
    repeat (3) @(posedge clk); #1;
    checks++;
    if (err !== want_err) $display("FAIL err_sticky: got %b, required %b", err, want_err);
    else passes++;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    checks++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b, required 0", err);
    else passes++;
    drain("err");
  endtask

  initial begin
    rst_n = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0; s_rvalid = 1'b0;
    cfg_tid = 2'b10; cfg_tdest = 1'b1; m_tready = 1'b0; err_clr = 1'b0;
    test_reset();
    test_basic();
    test_frame();
    test_backpressure();
    test_partial();
    test_reset_mid();
    test_random();
    test_err();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
